// File: rtl/debug_pkg.sv
// debug_pkg -- shared definitions for the debug host.
// Holds opcode constants, the FSM state encoding, the core control-word
// layout with its idle value, and small opcode classification helpers.
package debug_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_WR_A   = 4'd1;
  localparam logic [3:0] OP_WR_B   = 4'd2;
  localparam logic [3:0] OP_WR_OUT = 4'd3;
  localparam logic [3:0] OP_WR_PC  = 4'd4;
  localparam logic [3:0] OP_WR_MEM = 4'd5;
  localparam logic [3:0] OP_RD_A   = 4'd6;
  localparam logic [3:0] OP_RD_B   = 4'd7;
  localparam logic [3:0] OP_RD_MEM = 4'd8;
  localparam logic [3:0] OP_RD_PC  = 4'd9;
  localparam logic [3:0] OP_RD_ALU = 4'd10;
  localparam logic [3:0] OP_CLR    = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_DRAIN = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Five active-high controls followed by fifteen active-low controls.
  typedef struct packed {
    logic clr;
    logic hlt;
    logic ce;
    logic su;
    logic ri;
    logic ai_n;
    logic bi_n;
    logic oi_n;
    logic ii_n;
    logic j_n;
    logic fi_n;
    logic mi_n;
    logic do_n;
    logic ao_n;
    logic bo_n;
    logic io_n;
    logic co_n;
    logic eo_n;
    logic ro_n;
    logic no_n;
  } ctrl_word_t;

  // Idle: every active-high control low, every active-low control high.
  localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'({5'b00000, 15'h7FFF});

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op > OP_CLR);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_WR_MEM) || (op == OP_RD_MEM);
  endfunction

  // Ops whose result is captured from the core bus.
  function automatic logic op_is_read(input logic [3:0] op);
    logic r;
    case (op)
      OP_RD_A, OP_RD_B, OP_RD_MEM, OP_RD_PC, OP_RD_ALU: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debug_word.sv
// debug_word -- combinational decoder from (FSM state, latched opcode) to
// the core control word and the value driven onto the core bus.
// Ports: state (FSM state), op/addr/data (latched command fields),
//        ctrl (control word), dbg_data (bus drive value, 0 unless do_n low).
module debug_word
  import debug_pkg::*;
(
  input  state_t       state,
  input  logic [3:0]   op,
  input  logic [7:0]   addr,
  input  logic [7:0]   data,
  output ctrl_word_t   ctrl,
  output logic [7:0]   dbg_data
);

  logic [7:0] drive_s;

  // Decode the control word and bus value for the current execute step.
  always_comb begin
    ctrl    = CTRL_IDLE;
    drive_s = 8'h00;
    case (state)
      ST_EXEC1: begin
        case (op)
          OP_WR_A:   begin ctrl.do_n = 1'b0; ctrl.ai_n = 1'b0; drive_s = data; end
          OP_WR_B:   begin ctrl.do_n = 1'b0; ctrl.bi_n = 1'b0; drive_s = data; end
          OP_WR_OUT: begin ctrl.do_n = 1'b0; ctrl.oi_n = 1'b0; drive_s = data; end
          OP_WR_PC:  begin ctrl.do_n = 1'b0; ctrl.j_n  = 1'b0; drive_s = data; end
          OP_RD_A:   ctrl.ao_n = 1'b0;
          OP_RD_B:   ctrl.bo_n = 1'b0;
          OP_RD_PC:  ctrl.co_n = 1'b0;
          OP_RD_ALU: ctrl.eo_n = 1'b0;
          OP_CLR:    ctrl.clr  = 1'b1;
          // Memory ops first load the address register from the bus.
          OP_WR_MEM, OP_RD_MEM: begin ctrl.do_n = 1'b0; ctrl.mi_n = 1'b0; drive_s = addr; end
          default:   ctrl = CTRL_IDLE;
        endcase
      end
      ST_EXEC2: begin
        case (op)
          OP_WR_MEM: begin ctrl.do_n = 1'b0; ctrl.ri = 1'b1; drive_s = data; end
          OP_RD_MEM: ctrl.ro_n = 1'b0;
          default:   ctrl = CTRL_IDLE;
        endcase
      end
      default: ctrl = CTRL_IDLE;
    endcase
    // Never present a value while the host is not driving the bus.
    if (ctrl.do_n) begin
      dbg_data = 8'h00;
    end else begin
      dbg_data = drive_s;
    end
  end

endmodule

// File: rtl/debug_host.sv
// debug_host -- executes single debug commands on a halted core.
// A command is accepted in IDLE, debug entry is requested, one or two
// execute steps drive the core control lines, the host waits for the core
// to release debug, then a one-cycle response is produced.
// Ports: CLK/RESETn; CMD_VALID/CMD_READY/CMD_OP/CMD_ADDR/CMD_DATA command;
//        RSP_VALID/RSP_DATA/RSP_ERR/RSP_HALTED response; DEBUG_REQUEST/
//        DEBUG_ACK handshake; DEBUG_DATA + D_* core controls; BUS, HALTED.
// Build option: define DBG_TIMEOUT_EN to abort REQ/DRAIN waits after
// ACK_TIMEOUT cycles; otherwise those states wait indefinitely.
module debug_host
  import debug_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_OP,
  input  logic [7:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic       RSP_HALTED,
  output logic       DEBUG_REQUEST,
  input  logic       DEBUG_ACK,
  output logic [7:0] DEBUG_DATA,
  output logic       D_CLR, D_HLT, D_CE, D_SU, D_RI,
  output logic       D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn,
  output logic       D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn,
  input  logic [7:0] BUS,
  input  logic       HALTED
);

  if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 255)) begin : g_bad_ack_timeout
    $error("ACK_TIMEOUT must lie in 1..255");
  end

  state_t     state_r;
  logic [3:0] op_r;
  logic [7:0] addr_r, data_r, cap_data_r;
  logic       cap_err_r;
  logic       rsp_valid_r, rsp_err_r, rsp_halted_r;
  logic [7:0] rsp_data_r;
  logic       resp_enter_s, rsp_err_nxt_s, timeout_s;
  logic [7:0] rsp_data_nxt_s;
  ctrl_word_t ctrl_s;

`ifdef DBG_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] tmo_cnt_r;
  logic       waiting_s;

  // Waiting means the ACK level needed to leave REQ or DRAIN is absent.
  always_comb begin
    if (state_r == ST_REQ) begin
      waiting_s = !DEBUG_ACK;
    end else if (state_r == ST_DRAIN) begin
      waiting_s = DEBUG_ACK;
    end else begin
      waiting_s = 1'b0;
    end
  end

  assign timeout_s = waiting_s && (tmo_cnt_r == TMO_LAST);

  // Count consecutive waiting cycles; cleared whenever the wait ends.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt_r <= 8'd0;
    end else if (waiting_s && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Decide whether this edge completes the command, and with what result.
  always_comb begin
    resp_enter_s   = 1'b0;
    rsp_err_nxt_s  = 1'b0;
    rsp_data_nxt_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (CMD_VALID && op_is_illegal(CMD_OP)) begin
          resp_enter_s  = 1'b1;
          rsp_err_nxt_s = 1'b1;
        end else begin
          resp_enter_s  = 1'b0;
        end
      end
      ST_REQ: begin
        if (timeout_s) begin
          resp_enter_s  = 1'b1;
          rsp_err_nxt_s = 1'b1;
        end else begin
          resp_enter_s  = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (timeout_s) begin
          resp_enter_s   = 1'b1;
          rsp_err_nxt_s  = 1'b1;
        end else if (!DEBUG_ACK) begin
          resp_enter_s   = 1'b1;
          rsp_err_nxt_s  = cap_err_r;
          rsp_data_nxt_s = cap_data_r;
        end else begin
          resp_enter_s   = 1'b0;
        end
      end
      default: resp_enter_s = 1'b0;
    endcase
  end

  // Command sequencer, result capture and registered response outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_NOP;
      addr_r       <= 8'h00;
      data_r       <= 8'h00;
      cap_data_r   <= 8'h00;
      cap_err_r    <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 8'h00;
      rsp_err_r    <= 1'b0;
      rsp_halted_r <= 1'b0;
    end else begin
      rsp_valid_r <= resp_enter_s;
      if (resp_enter_s) begin
        rsp_data_r   <= rsp_data_nxt_s;
        rsp_err_r    <= rsp_err_nxt_s;
        rsp_halted_r <= HALTED;
      end
      case (state_r)
        ST_IDLE: begin
          if (CMD_VALID) begin
            op_r       <= CMD_OP;
            addr_r     <= CMD_ADDR;
            data_r     <= CMD_DATA;
            cap_data_r <= 8'h00;
            cap_err_r  <= 1'b0;
            state_r    <= resp_enter_s ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ: begin
          if (resp_enter_s) begin
            state_r <= ST_RESP;
          end else if (DEBUG_ACK) begin
            state_r <= (op_r == OP_NOP) ? ST_DRAIN : ST_EXEC1;
          end
        end
        ST_EXEC1: begin
          if (!DEBUG_ACK) begin
            cap_err_r  <= 1'b1;
            cap_data_r <= 8'h00;
            state_r    <= ST_DRAIN;
          end else if (op_is_mem(op_r)) begin
            state_r <= ST_EXEC2;
          end else begin
            if (op_is_read(op_r)) begin
              cap_data_r <= BUS;
            end
            state_r <= ST_DRAIN;
          end
        end
        ST_EXEC2: begin
          if (!DEBUG_ACK) begin
            cap_err_r  <= 1'b1;
            cap_data_r <= 8'h00;
          end else if (op_r == OP_RD_MEM) begin
            cap_data_r <= BUS;
          end
          state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (resp_enter_s) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  debug_word u_word (
    .state    (state_r),
    .op       (op_r),
    .addr     (addr_r),
    .data     (data_r),
    .ctrl     (ctrl_s),
    .dbg_data (DEBUG_DATA)
  );

  assign CMD_READY     = (state_r == ST_IDLE);
  assign DEBUG_REQUEST = (state_r == ST_REQ) || (state_r == ST_EXEC1) ||
                         (state_r == ST_EXEC2);
  assign RSP_VALID     = rsp_valid_r;
  assign RSP_DATA      = rsp_data_r;
  assign RSP_ERR       = rsp_err_r;
  assign RSP_HALTED    = rsp_halted_r;

  assign D_CLR = ctrl_s.clr;   assign D_HLT = ctrl_s.hlt;
  assign D_CE  = ctrl_s.ce;    assign D_SU  = ctrl_s.su;
  assign D_RI  = ctrl_s.ri;
  assign D_AIn = ctrl_s.ai_n;  assign D_BIn = ctrl_s.bi_n;
  assign D_OIn = ctrl_s.oi_n;  assign D_IIn = ctrl_s.ii_n;
  assign D_Jn  = ctrl_s.j_n;   assign D_FIn = ctrl_s.fi_n;
  assign D_MIn = ctrl_s.mi_n;  assign D_DOn = ctrl_s.do_n;
  assign D_AOn = ctrl_s.ao_n;  assign D_BOn = ctrl_s.bo_n;
  assign D_IOn = ctrl_s.io_n;  assign D_COn = ctrl_s.co_n;
  assign D_EOn = ctrl_s.eo_n;  assign D_ROn = ctrl_s.ro_n;
  assign D_NOn = ctrl_s.no_n;

endmodule

// File: tb/tb_debug_host.sv
// tb_debug_host -- directed bench for debug_host with a core model that
// raises DEBUG_ACK one cycle after DEBUG_REQUEST and drops it one cycle
// after release, and a bus model returning fixed values for reads.
module tb_debug_host;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       CMD_VALID, CMD_READY;
  logic [3:0] CMD_OP;
  logic [7:0] CMD_ADDR, CMD_DATA;
  logic       RSP_VALID, RSP_ERR, RSP_HALTED;
  logic [7:0] RSP_DATA;
  logic       DEBUG_REQUEST;
  logic       DEBUG_ACK = 1'b0;
  logic [7:0] DEBUG_DATA;
  logic       D_CLR, D_HLT, D_CE, D_SU, D_RI;
  logic       D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn;
  logic       D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn;
  logic [7:0] BUS;
  logic       HALTED;

  logic       ack_hold_low;
  int         n_checks = 0;
  int         n_errors = 0;

  // Results of the last run() call
  int         rsp_cyc, n_req, n_do, mi_cyc, ro_cyc, ai_cyc, ri_n, clr_n;
  logic [7:0] dd0, dd1, r_data;
  logic       r_err, r_halt;

  wire [14:0] low_w  = {D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn,
                        D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn};
  wire [4:0]  high_w = {D_CLR, D_HLT, D_CE, D_SU, D_RI};

  debug_host #(.ACK_TIMEOUT(4)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .RSP_HALTED(RSP_HALTED),
    .DEBUG_REQUEST(DEBUG_REQUEST), .DEBUG_ACK(DEBUG_ACK), .DEBUG_DATA(DEBUG_DATA),
    .D_CLR(D_CLR), .D_HLT(D_HLT), .D_CE(D_CE), .D_SU(D_SU), .D_RI(D_RI),
    .D_AIn(D_AIn), .D_BIn(D_BIn), .D_OIn(D_OIn), .D_IIn(D_IIn), .D_Jn(D_Jn),
    .D_FIn(D_FIn), .D_MIn(D_MIn), .D_DOn(D_DOn),
    .D_AOn(D_AOn), .D_BOn(D_BOn), .D_IOn(D_IOn), .D_COn(D_COn), .D_EOn(D_EOn),
    .D_ROn(D_ROn), .D_NOn(D_NOn),
    .BUS(BUS), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  // Core handshake model: ACK follows REQUEST with one cycle of latency.
  always @(posedge CLK) DEBUG_ACK <= DEBUG_REQUEST && !ack_hold_low;

  // Core bus model.
  always_comb begin
    if (!D_DOn)      BUS = DEBUG_DATA;
    else if (!D_ROn) BUS = 8'hC3;
    else if (!D_AOn) BUS = 8'h3C;
    else if (!D_EOn) BUS = 8'hE1;
    else             BUS = 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and observe 12 cycles after the accept edge.
  // Cycle k is the interval following accept edge + k.
  task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                     input int drop_at);
    rsp_cyc = -1; n_req = 0; n_do = 0; mi_cyc = -1; ro_cyc = -1; ai_cyc = -1;
    ri_n = 0; clr_n = 0; dd0 = 8'h00; dd1 = 8'h00;
    r_data = 8'hxx; r_err = 1'bx; r_halt = 1'bx;
    @(negedge CLK);
    chk("ready_before_accept", {31'd0, CMD_READY}, 32'd1);
    CMD_OP = op; CMD_ADDR = a; CMD_DATA = d; CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (k == drop_at) ack_hold_low = 1'b1;
      if (DEBUG_REQUEST) n_req++;
      if (!D_DOn) begin
        if (n_do == 0) dd0 = DEBUG_DATA; else dd1 = DEBUG_DATA;
        n_do++;
      end
      if (!D_MIn && mi_cyc < 0) mi_cyc = k;
      if (!D_ROn && ro_cyc < 0) ro_cyc = k;
      if (!D_AIn && ai_cyc < 0) ai_cyc = k;
      if (D_RI)  ri_n++;
      if (D_CLR) clr_n++;
      if (RSP_VALID && rsp_cyc < 0) begin
        rsp_cyc = k; r_data = RSP_DATA; r_err = RSP_ERR; r_halt = RSP_HALTED;
      end
    end
    ack_hold_low = 1'b0;
  endtask

  initial begin
    int seen;
    RESETn = 1'b0; CMD_VALID = 1'b0; CMD_OP = 4'd0; CMD_ADDR = 8'h00;
    CMD_DATA = 8'h00; HALTED = 1'b0; ack_hold_low = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ready",  {31'd0, CMD_READY},     32'd1);
    chk("rst_dreq",   {31'd0, DEBUG_REQUEST}, 32'd0);
    chk("rst_rspv",   {31'd0, RSP_VALID},     32'd0);
    chk("rst_rsp",    {23'd0, RSP_ERR, RSP_DATA}, 32'd0);
    chk("rst_low",    {17'd0, low_w},         32'h7FFF);
    chk("rst_high",   {27'd0, high_w},        32'd0);
    chk("rst_ddata",  {24'd0, DEBUG_DATA},    32'd0);
    RESETn = 1'b1;

    // WR_A 0x5A with core halted
    HALTED = 1'b1;
    run(4'd1, 8'h00, 8'h5A, -1);
    HALTED = 1'b0;
    chk("wra_rsp_cyc", rsp_cyc, 32'd5);
    chk("wra_ndo",     n_do, 32'd1);
    chk("wra_ddata",   {24'd0, dd0}, 32'h5A);
    chk("wra_ai_cyc",  ai_cyc, 32'd2);
    chk("wra_nreq",    n_req, 32'd3);
    chk("wra_result",  {22'd0, r_halt, r_err, r_data}, {22'd0, 1'b1, 1'b0, 8'h00});

    // RD_MEM 0x0F: address phase then memory read
    run(4'd8, 8'h0F, 8'h00, -1);
    chk("rdm_rsp_cyc", rsp_cyc, 32'd6);
    chk("rdm_mi_cyc",  mi_cyc, 32'd2);
    chk("rdm_addr",    {24'd0, dd0}, 32'h0F);
    chk("rdm_ro_cyc",  ro_cyc, 32'd3);
    chk("rdm_result",  {23'd0, r_err, r_data}, {23'd0, 1'b0, 8'hC3});

    // RD_A and RD_ALU
    run(4'd6, 8'h00, 8'h00, -1);
    chk("rda_rsp_cyc", rsp_cyc, 32'd5);
    chk("rda_result",  {23'd0, r_err, r_data}, {23'd0, 1'b0, 8'h3C});
    run(4'd10, 8'h00, 8'h00, -1);
    chk("rdalu_result", {23'd0, r_err, r_data}, {23'd0, 1'b0, 8'hE1});

    // Illegal opcode: immediate error, no debug entry, data cleared
    run(4'd13, 8'h00, 8'h00, -1);
    chk("ill_rsp_cyc", rsp_cyc, 32'd0);
    chk("ill_nreq",    n_req, 32'd0);
    chk("ill_result",  {23'd0, r_err, r_data}, {23'd0, 1'b1, 8'h00});

    // WR_MEM 0x20 <- 0x77
    run(4'd5, 8'h20, 8'h77, -1);
    chk("wrm_rsp_cyc", rsp_cyc, 32'd6);
    chk("wrm_ndo",     n_do, 32'd2);
    chk("wrm_data",    {16'd0, dd0, dd1}, 32'h2077);
    chk("wrm_ri",      ri_n, 32'd1);

    // CLR and NOP
    run(4'd11, 8'h00, 8'h00, -1);
    chk("clr_cnt",     clr_n, 32'd1);
    chk("clr_rsp_cyc", rsp_cyc, 32'd5);
    run(4'd0, 8'h00, 8'h00, -1);
    chk("nop_rsp_cyc", rsp_cyc, 32'd4);
    chk("nop_ndo",     n_do, 32'd0);

    // RD_A with ACK dropped during EXEC1
    run(4'd6, 8'h00, 8'h00, 1);
    chk("abort_rsp_cyc", rsp_cyc, 32'd4);
    chk("abort_result",  {23'd0, r_err, r_data}, {23'd0, 1'b1, 8'h00});

`ifdef DBG_TIMEOUT_EN
    // ACK never rises: timeout after 4 waiting cycles in REQ
    ack_hold_low = 1'b1;
    run(4'd1, 8'h00, 8'h11, -1);
    chk("tmo_rsp_cyc", rsp_cyc, 32'd4);
    chk("tmo_nreq",    n_req, 32'd4);
    chk("tmo_err",     {31'd0, r_err}, 32'd1);
`endif

    // Reset during EXEC2 of WR_MEM
    @(negedge CLK);
    CMD_OP = 4'd5; CMD_ADDR = 8'h30; CMD_DATA = 8'h99; CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rmid_exec2", {22'd0, D_RI, D_DOn, DEBUG_DATA}, {22'd0, 1'b1, 1'b0, 8'h99});
    #2 RESETn = 1'b0;
    #1;
    chk("rmid_low",   {17'd0, low_w},  32'h7FFF);
    chk("rmid_high",  {27'd0, high_w}, 32'd0);
    chk("rmid_out",   {22'd0, DEBUG_REQUEST, RSP_VALID, DEBUG_DATA}, 32'd0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (RSP_VALID) seen++;
    end
    chk("rmid_no_rsp", seen, 32'd0);
    chk("rmid_ready",  {31'd0, CMD_READY}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debug_host.md
DEBUG_HOST -- requirements
Module: debug_host

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64: cycles to wait for DEBUG_ACK before aborting (range 1..255).
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RESETn  input  1  asynchronous active-low reset.
REQ-004 CMD_VALID  input  1  command offered.
REQ-005 CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY at a rising edge.
REQ-006 CMD_OP  input  4  opcode.
REQ-007 CMD_ADDR  input  8  memory address for WR_MEM/RD_MEM.
REQ-008 CMD_DATA  input  8  write data.
REQ-009 RSP_VALID  output  1  one-cycle response strobe.
REQ-010 RSP_DATA  output  8  read result, held until next response.
REQ-011 RSP_ERR  output  1  error flag, valid with RSP_VALID.
REQ-012 RSP_HALTED  output  1  HALTED sampled at completion.
REQ-013 DEBUG_REQUEST  output  1  request core entry to debug.
REQ-014 DEBUG_ACK  input  1  core is in debug.
REQ-015 DEBUG_DATA  output  8  value driven onto core bus via D_DOn.
REQ-016 D_CLR, D_HLT, D_CE, D_SU, D_RI  output  1 each  active-high controls, idle 0.
REQ-017 D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn  output  1 each  active-low controls, idle 1.
REQ-018 BUS  input  8  core bus, captured for reads.
REQ-019 HALTED  input  1  core halt status.

Function
REQ-020 FSM states: IDLE, REQ, EXEC1, EXEC2, DRAIN, RESP; CMD_READY=1 only in IDLE.
REQ-021 Opcodes: 0 NOP, 1 WR_A, 2 WR_B, 3 WR_OUT, 4 WR_PC, 5 WR_MEM, 6 RD_A, 7 RD_B, 8 RD_MEM, 9 RD_PC, 10 RD_ALU, 11 CLR; 12-15 illegal.
REQ-022 Accept latches op/addr/data; illegal op goes IDLE->RESP directly, RSP_ERR=1, DEBUG_REQUEST never asserted.
REQ-023 DEBUG_REQUEST=1 in REQ, EXEC1, EXEC2; 0 elsewhere.
REQ-024 REQ->EXEC1 when DEBUG_ACK=1 sampled; NOP goes REQ->DRAIN.
REQ-025 EXEC1 words: WR_A DOn+AIn; WR_B DOn+BIn; WR_OUT DOn+OIn; WR_PC DOn+Jn; RD_A AOn; RD_B BOn; RD_PC COn; RD_ALU EOn; CLR D_CLR; WR_MEM/RD_MEM DOn+MIn with DEBUG_DATA=addr.
REQ-026 EXEC2 (WR_MEM/RD_MEM only): WR_MEM DOn+D_RI, DEBUG_DATA=data; RD_MEM ROn.
REQ-027 Write ops drive DEBUG_DATA=CMD_DATA latched; DEBUG_DATA=0 when D_DOn=1.
REQ-028 Reads capture BUS into RSP_DATA at the edge ending the bus-driving EXEC state; writes/NOP/CLR return RSP_DATA=0.
REQ-029 D_* and DEBUG_DATA decoded from registered state only; no input-to-output combinational path.
REQ-030 DRAIN holds DEBUG_REQUEST=0 until DEBUG_ACK=0 sampled, then RESP.
REQ-031 RESP lasts one cycle: RSP_VALID=1, RSP_HALTED=HALTED; next state IDLE.
REQ-032 DEBUG_ACK=0 sampled in EXEC1/EXEC2: abort to DRAIN, RSP_ERR=1, RSP_DATA=0.
REQ-033 With ack 1 cycle after request/release, RSP_VALID rises exactly 5 clocks after accept edge (6 for WR_MEM/RD_MEM).

Reset
REQ-034 RESETn low asynchronously forces IDLE, DEBUG_REQUEST=0, all D_* idle, DEBUG_DATA=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, RSP_HALTED=0, timeout counter 0.
REQ-035 Reset mid-command discards it; no response produced.

Configuration
REQ-036 DBG_TIMEOUT_EN defined: 8-bit counter in REQ and DRAIN; ACK_TIMEOUT cycles without expected ACK level -> RESP, RSP_ERR=1, DEBUG_REQUEST=0.
REQ-037 DBG_TIMEOUT_EN undefined: REQ/DRAIN wait indefinitely; counter absent.

Structure
REQ-038 Package debug_pkg holds opcode constants, FSM state encoding, idle control-word constant.
REQ-039 Sub-module debug_word: combinational (state, op) -> control word and DEBUG_DATA decoder.

Verification
REQ-040 WR_A data 0x5A, 1-cycle-ack model -> one EXEC cycle D_DOn=0, D_AIn=0, DEBUG_DATA=0x5A; RSP_VALID 5 clocks after accept, RSP_DATA=0, RSP_ERR=0.
REQ-041 RD_MEM addr 0x0F, model returns 0xC3 on ROn -> EXEC1 MIn with DEBUG_DATA=0x0F, EXEC2 ROn; RSP_DATA=0xC3 at 6 clocks.
REQ-042 CMD_OP=13 -> no DEBUG_REQUEST, RSP_VALID next cycle, RSP_ERR=1.
REQ-043 DBG_TIMEOUT_EN, ACK_TIMEOUT=4, ACK never rises -> RSP_ERR=1, DEBUG_REQUEST=0 by 6 clocks after accept.
REQ-044 ACK dropped during EXEC1 of RD_A -> RSP_ERR=1, RSP_DATA=0.
REQ-045 RESETn low during EXEC2 of WR_MEM -> all outputs idle immediately, no RSP_VALID, CMD_READY=1 after release.
